pll_reconfig_responder: RTL and testbench

PLL_RECONFIG_RESPONDER -- requirements
Module: pll_reconfig_responder

---
 rtl/pll_reconfig_responder.sv | 124 ++++++++++++
 tb/tb_pll_reconfig_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_responder.sv
// pll_reconfig_responder: register-mapped PLL reconfiguration controller with shadow/active counter settings.
module pll_reconfig_responder #(
  parameter int RECONFIG_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_read,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic [17:0] pll_m,
  output logic [17:0] pll_n,
  output logic [17:0] pll_c,
  output logic [8:0]  pll_m_div,
  output logic [8:0]  pll_n_div,
  output logic [8:0]  pll_c_div,
  output logic [3:0]  pll_bw,
  output logic [2:0]  pll_cp,
  output logic        cfg_update
);
  typedef enum logic [1:0] {IDLE, APPLY, BUSY, LOCK} state_t;
  state_t state;
  logic mode, lock_error;
  logic [17:0] sh_m, sh_n, sh_c;
  logic [3:0] sh_bw;
  logic [2:0] sh_cp;
  logic [15:0] cnt;
  logic wr, rd, start;
  logic [31:0] rdata;
  logic unused_wd;
  function automatic logic [8:0] div_of(input logic [17:0] w);
    return w[16] ? 9'd1 : {1'b0, w[15:8]} + {1'b0, w[7:0]};
  endfunction
  assign unused_wd = ^mgmt_writedata[31:18];
  assign mgmt_waitrequest = ~mode & (state != IDLE);
  assign wr = ~mgmt_waitrequest & mgmt_write;
  assign rd = ~mgmt_waitrequest & mgmt_read & ~mgmt_write;
  assign start = wr & (mgmt_address == 6'h02) & mgmt_writedata[0];
  always_comb begin
    rdata = '0;
    case (mgmt_address)
      6'h00: rdata = {31'b0, mode};
      6'h01: rdata = {30'b0, lock_error, state == IDLE};
      6'h03: rdata = {14'b0, sh_n};
      6'h04: rdata = {14'b0, sh_m};
      6'h05: rdata = {14'b0, sh_c};
      6'h08: rdata = {28'b0, sh_bw};
      6'h09: rdata = {29'b0, sh_cp};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      mode <= 1'b0;
      lock_error <= 1'b0;
      cnt <= '0;
      sh_m <= 18'h10000;
      sh_n <= 18'h10000;
      sh_c <= 18'h10000;
      sh_bw <= '0;
      sh_cp <= '0;
      pll_m <= 18'h10000;
      pll_n <= 18'h10000;
      pll_c <= 18'h10000;
      pll_m_div <= 9'd1;
      pll_n_div <= 9'd1;
      pll_c_div <= 9'd1;
      pll_bw <= '0;
      pll_cp <= '0;
      mgmt_readdata <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (rd) mgmt_readdata <= rdata;
      if (wr)
        case (mgmt_address)
          6'h00: mode <= mgmt_writedata[0];
          6'h03: sh_n <= mgmt_writedata[17:0];
          6'h04: sh_m <= mgmt_writedata[17:0];
          6'h05: sh_c <= mgmt_writedata[17:0];
          6'h08: sh_bw <= mgmt_writedata[3:0];
          6'h09: sh_cp <= mgmt_writedata[2:0];
          default: ;
        endcase
      case (state)
        IDLE:
          if (start) begin
            // active settings land together with the cfg_update pulse, visible during APPLY
            state <= APPLY;
            lock_error <= 1'b0;
            cfg_update <= 1'b1;
            pll_m <= sh_m;
            pll_n <= sh_n;
            pll_c <= sh_c;
            pll_m_div <= div_of(sh_m);
            pll_n_div <= div_of(sh_n);
            pll_c_div <= div_of(sh_c);
            pll_bw <= sh_bw;
            pll_cp <= sh_cp;
          end
        APPLY: begin
          state <= BUSY;
          cnt <= '0;
        end
        BUSY:
          if (cnt == 16'(RECONFIG_CYCLES - 1)) begin
            state <= LOCK;
            cnt <= '0;
          end else cnt <= cnt + 16'd1;
        LOCK:
          if (pll_locked) state <= IDLE;
          else if (cnt == 16'(LOCK_TIMEOUT - 1)) begin
            state <= IDLE;
            lock_error <= 1'b1;
          end else cnt <= cnt + 16'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reconfig_responder.sv
// tb_pll_reconfig_responder: directed and random stimulus checked every cycle against a cycle-count reference model.
module tb_pll_reconfig_responder;
  localparam int RC = 8;
  localparam int LT = 20;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [5:0] mgmt_address = '0;
  logic mgmt_read = 1'b0, mgmt_write = 1'b0, pll_locked = 1'b0;
  logic [31:0] mgmt_writedata = '0, mgmt_readdata;
  logic mgmt_waitrequest, cfg_update;
  logic [17:0] pll_m, pll_n, pll_c;
  logic [8:0] pll_m_div, pll_n_div, pll_c_div;
  logic [3:0] pll_bw;
  logic [2:0] pll_cp;
  always #5 clk = ~clk;
  pll_reconfig_responder #(.RECONFIG_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n), .mgmt_address(mgmt_address), .mgmt_read(mgmt_read),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked), .pll_m(pll_m), .pll_n(pll_n),
    .pll_c(pll_c), .pll_m_div(pll_m_div), .pll_n_div(pll_n_div), .pll_c_div(pll_c_div),
    .pll_bw(pll_bw), .pll_cp(pll_cp), .cfg_update(cfg_update)
  );
  int checks = 0, errors = 0;
  bit m_mode, m_busy, m_err, m_cfg, last_acc;
  int m_t, m_wait;
  logic [17:0] m_sh[3], m_act[3];
  logic [3:0] m_bw, m_abw;
  logic [2:0] m_cp, m_acp;
  logic [31:0] m_rd;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int div(input logic [17:0] w);
    return w[16] ? 1 : int'(w[15:8]) + int'(w[7:0]);
  endfunction
  function automatic logic [31:0] reg_val(input int a);
    if (a == 0) return {31'b0, m_mode};
    if (a == 1) return {30'b0, m_err, !m_busy};
    if (a >= 3 && a <= 5) return {14'b0, m_sh[a-3]};
    if (a == 8) return {28'b0, m_bw};
    if (a == 9) return {29'b0, m_cp};
    return 32'b0;
  endfunction
  task automatic model_reset;
    m_mode = 0; m_busy = 0; m_err = 0; m_cfg = 0; m_t = 0; m_wait = 0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 18'h10000; m_act[i] = 18'h10000; end
    m_bw = 0; m_cp = 0; m_abw = 0; m_acp = 0; m_rd = 0;
  endtask
  // Reconfiguration timeline: t=0 apply, t=1..RC busy, t>RC waiting for lock.
  task automatic model_edge;
    bit w, r;
    if (!reset_n) begin model_reset; last_acc = 0; return; end
    last_acc = m_mode || !m_busy;
    w = last_acc && mgmt_write;
    r = last_acc && mgmt_read && !mgmt_write;
    m_cfg = 0;
    if (r) m_rd = reg_val(int'(mgmt_address));
    if (m_busy) begin
      if (m_t <= RC) m_t++;
      else if (pll_locked) m_busy = 0;
      else begin
        m_wait++;
        if (m_wait == LT) begin m_busy = 0; m_err = 1; end
      end
    end else if (w && mgmt_address == 2 && mgmt_writedata[0]) begin
      m_busy = 1; m_t = 0; m_wait = 0; m_err = 0; m_cfg = 1;
      m_act = m_sh; m_abw = m_bw; m_acp = m_cp;
    end
    if (w)
      case (int'(mgmt_address))
        0: m_mode = mgmt_writedata[0];
        3, 4, 5: m_sh[mgmt_address-3] = mgmt_writedata[17:0];
        8: m_bw = mgmt_writedata[3:0];
        9: m_cp = mgmt_writedata[2:0];
        default: ;
      endcase
  endtask
  task automatic step;
    @(negedge clk);
    check("waitrequest", mgmt_waitrequest, !m_mode && m_busy);
    check("readdata", mgmt_readdata, m_rd);
    check("cfg_update", cfg_update, m_cfg);
    check("active_mnc", {pll_m, pll_n, pll_c}, {m_act[1], m_act[0], m_act[2]});
    check("div_mnc", {pll_m_div, pll_n_div, pll_c_div}, {9'(div(m_act[1])), 9'(div(m_act[0])), 9'(div(m_act[2]))});
    check("bw_cp", {pll_bw, pll_cp}, {m_abw, m_acp});
    model_edge;
    @(posedge clk);
    #1;
  endtask
  task automatic access(input bit r, input bit w, input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    mgmt_read = r; mgmt_write = w; mgmt_address = a; mgmt_writedata = d;
    do begin step; n++; end while (!last_acc && n < 500);
    check("access_accepted", last_acc, 1'b1);
    mgmt_read = 0; mgmt_write = 0;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d); access(0, 1, a, d); endtask
  task automatic rd(input logic [5:0] a); access(1, 0, a, 0); endtask
  task automatic wait_idle;
    int n = 0;
    while (m_busy && n < 2000) begin step; n++; end
    check("idle_reached", m_busy, 1'b0);
  endtask
  // Continuously reads STATUS from the current (APPLY) cycle; n = cycle whose read first reports done.
  task automatic poll_done(output int n);
    mgmt_read = 1; mgmt_address = 6'h01;
    for (n = 0; n < 2000; n++) begin
      step;
      if (mgmt_readdata[0]) break;
    end
    mgmt_read = 0;
  endtask
  initial begin
    int n;
    model_reset;
    @(posedge clk); #1;
    step;
    check("rst_m_div", pll_m_div, 9'd1);
    check("rst_m", pll_m, 18'h10000);
    reset_n = 1;
    step;
    wr(6'h00, 1); wr(6'h04, 32'h02525); wr(6'h03, 32'h20302); wr(6'h05, 32'h20302);
    wr(6'h02, 1);
    check("start_cfg", cfg_update, 1'b1);
    check("start_m_div", pll_m_div, 9'd74);
    check("start_n_div", pll_n_div, 9'd5);
    check("start_c_div", pll_c_div, 9'd5);
    pll_locked = 1;
    wait_idle;
    wr(6'h02, 1);
    poll_done(n);
    check("done_cycle", n, RC + 2);
    wr(6'h00, 0);
    wr(6'h02, 1);
    mgmt_read = 1; mgmt_address = 6'h01; n = 0;
    while (mgmt_waitrequest && n < 500) begin n++; step; end
    step;
    mgmt_read = 0;
    check("stall_cycles", n, RC + 2);
    check("stalled_read", mgmt_readdata, 32'h1);
    wr(6'h00, 1);
    pll_locked = 0;
    wr(6'h02, 1);
    poll_done(n);
    check("timeout_cycle", n, RC + 1 + LT);
    check("status_err", mgmt_readdata, 32'h3);
    wr(6'h02, 1);
    rd(6'h01);
    check("err_cleared", mgmt_readdata, 32'h0);
    pll_locked = 1;
    wait_idle;
    wr(6'h04, 32'h00A05);
    wr(6'h02, 1);
    repeat (3) step;
    wr(6'h02, 1);
    wr(6'h04, 32'h01003);
    check("busy_no_cfg", cfg_update, 1'b0);
    check("busy_m_kept", pll_m, 18'h00A05);
    rd(6'h04);
    check("shadow_rb", mgmt_readdata, 32'h01003);
    wait_idle;
    wr(6'h02, 1);
    check("reapply_m", pll_m, 18'h01003);
    check("reapply_m_div", pll_m_div, 9'd19);
    repeat (4) step;
    reset_n = 0;
    step;
    reset_n = 1;
    check("abort_m", pll_m, 18'h10000);
    check("abort_m_div", pll_m_div, 9'd1);
    rd(6'h01);
    check("abort_status", mgmt_readdata, 32'h1);
    wr(6'h3F, 32'hFFFF_FFFF);
    rd(6'h3F);
    check("unmapped_rd", mgmt_readdata, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      reset_n = $urandom_range(0, 400) != 0;
      mgmt_read = 1'($urandom);
      mgmt_write = $urandom_range(0, 3) == 0;
      mgmt_address = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
      mgmt_writedata = $urandom;
      pll_locked = $urandom_range(0, 7) == 0;
      step;
    end
    reset_n = 1; mgmt_read = 0; mgmt_write = 0;
    step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
